apb_slave_regfile: RTL
======================

# apb_slave_regfile

APB completer (slave) holding a bank of read/write registers, sitting at the far end of the APB bus driven by the team's testbench master tasks. It decodes PADDR, inserts a configurable number of wait states via PREADY, commits writes and returns read data. It flags out-of-range accesses with PSLVERR. Register contents are exported in parallel so downstream logic can consume them.

## Interface
- APB_ADDR_WIDTH, 32: PADDR width (definesPkg value).
- APB_DATA_WIDTH, 32: PWDATA/PRDATA width (definesPkg value); must be 32 or 64.
- NUM_REGS, 16: number of registers; power of 2, 2..256.
- WAIT_STATES, 0: cycles of PREADY low in the access phase; 0..15.

Ports:
- apbClk  in  1  bus clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  APB_DATA_WIDTH  write data.
- PRDATA  out  APB_DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer-complete indicator.
- PSLVERR  out  1  error response, valid only while PREADY=1.
- regs_o  out  NUM_REGS*APB_DATA_WIDTH  all registers, reg i at bits [i*W +: W].

## Operation
- Address decode:
  - LSB = log2(APB_DATA_WIDTH/8).
  - Index = PADDR[LSB +: log2(NUM_REGS)].
  - In-range iff PADDR < NUM_REGS*(APB_DATA_WIDTH/8) and PADDR[LSB-1:0] == 0. Anything else is an error.
- FSM states:
  - IDLE:
    - At an edge with PSEL=1 and PENABLE=0 (setup phase): latch index, PWRITE and the error flag; load wait counter with WAIT_STATES; go to ACCESS.
    - For a read, PRDATA is loaded at the same edge: reg[index] if in range, else 0.
  - ACCESS:
    - If PSEL=0 at an edge: abort. Go to IDLE, no write, no error.
    - Else, if the counter is nonzero: decrement.
    - Else (PREADY=1, completion edge): for an in-range write, reg[index] <= PWDATA. Go to IDLE.
- PREADY = (state==ACCESS && counter==0), combinational from registered state.
- PSLVERR = PREADY && latched error flag. Error writes are dropped; error reads return 0.
- PADDR, PWRITE and PWDATA are sampled only at the setup edge (address, direction) and the completion edge (write data). Changes in between are ignored.
- PENABLE=1 while in IDLE (no setup phase seen) is ignored: stay in IDLE.
- PRDATA holds its value until the next read setup. Writes do not change PRDATA.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0, all registers=0, PRDATA=0.
  - Hence PREADY=0, PSLVERR=0, regs_o=0.
  - Reset mid-transfer aborts it; a write whose completion edge coincides with rst=1 is not committed.
- Transfer length:
  - Setup cycle plus (WAIT_STATES+1) access cycles.
  - WAIT_STATES=0 gives the minimum 2-cycle transfer, with PREADY high for the entire first access cycle.
- Read data is valid from the cycle after the setup edge. It is stable throughout the access phase, including the cycle after completion.
- A write is visible on regs_o and to reads starting the cycle after the completion edge.
- Back-to-back transfers: the completion edge returns the FSM to IDLE. A setup phase at the following edge is accepted, so no idle cycle is required.
- A read immediately following a write to the same index returns the new value, because its setup edge comes after the write's completion edge.
- The counter is 4 bits and never wraps: it is loaded only at setup and stops decrementing at 0.

## Test plan
- Reset then idle:
  - With rst high for 2 cycles, then 5 idle cycles: PREADY=0, PSLVERR=0, PRDATA=0 and regs_o=0 throughout.
- Zero-wait write/read (WAIT_STATES=0):
  - Write 0xDEADBEEF to addr 0x08, then read addr 0x08.
  - Each transfer completes in 2 cycles with PREADY=1 in the access cycle.
  - The read returns 0xDEADBEEF, and regs_o bits [95:64] = 0xDEADBEEF.
- Wait states (WAIT_STATES=3):
  - Write 0x12345678 to 0x3C.
  - PREADY stays low for 3 access cycles and rises in the 4th; reg 15 updates only after that edge. The read-back matches.
- Out-of-range and misaligned:
  - Write 0xFFFFFFFF to 0x40, then read 0x40 and 0x02.
  - Each completes with PSLVERR=1 and PRDATA=0; all registers are unchanged.
- Abort and back-to-back:
  - Drop PSEL in the second access cycle of a write to 0x04 (WAIT_STATES=2): reg 1 is unchanged, and the FSM accepts a setup at the next edge.
  - Then run 4 back-to-back transfers (write 0x0 <= 0xA5, read 0x0, write 0x0 <= 0x5A, read 0x0) with no idle cycles. The reads return 0xA5 and 0x5A.
- Reset mid-transfer:
  - Assert rst on the completion edge of a write of 0x77 to 0x0C: reg 3 stays 0, PREADY=0 on the next cycle, and normal transfers succeed after reset is released.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of read/write registers, programmable wait states,
// PSLVERR on out-of-range or misaligned accesses, and a parallel register export.
module apb_slave_regfile #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 16,
  parameter int WAIT_STATES    = 0
) (
  input  logic                               apbClk,
  input  logic                               rst,
  input  logic                               PSEL,
  input  logic                               PENABLE,
  input  logic                               PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
  input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
  output logic [APB_DATA_WIDTH-1:0]          PRDATA,
  output logic                               PREADY,
  output logic                               PSLVERR,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_o
);

  localparam int BYTES = APB_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_LIMIT = APB_ADDR_WIDTH'(NUM_REGS * BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q;
  logic                      write_q;
  logic                      err_q;
  logic                      setup;
  logic                      commit;
  logic                      addr_ok;
  logic [IDX_W-1:0]          addr_idx;
  logic [APB_DATA_WIDTH-1:0] regs [NUM_REGS];

  assign addr_idx = PADDR[LSB +: IDX_W];
  assign addr_ok  = (PADDR < ADDR_LIMIT) && (PADDR[LSB-1:0] == '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is committed.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = write_q && !err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge apbClk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
      // NOTE: the register bank is reset too, because it is exported on regs_o
      // and must read as zero out of reset; this rules out a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q   <= addr_idx;
        write_q <= PWRITE;
        err_q   <= !addr_ok;
        if (!PWRITE) PRDATA <= addr_ok ? regs[addr_idx] : '0;
      end
      if (commit) regs[idx_q] <= PWDATA;
    end
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
  assign PSLVERR = PREADY && err_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[g*APB_DATA_WIDTH +: APB_DATA_WIDTH] = regs[g];
  end

endmodule
